// File: rtl/bcd_to_bin_if.sv
// Handshake and data bundle for the BCD-to-binary converter.
// The entry logic is the master; the converter is the slave.
interface bcd_to_bin_if;
    logic       start;
    logic [3:0] centena;
    logic [3:0] dezena;
    logic [3:0] unidade;
    logic       negative;
    logic [7:0] out;
    logic       erro;
    logic       busy;
    logic       done;

    modport master (
        output start, centena, dezena, unidade, negative,
        input  out, erro, busy, done
    );

    modport slave (
        input  start, centena, dezena, unidade, negative,
        output out, erro, busy, done
    );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble).
// Sign plus three BCD digits in, 8-bit two's-complement value out.
// Fixed 11-clock latency from start to the one-cycle done pulse.
module bcd_to_bin (
    input logic         clk,
    input logic         rst,
    bcd_to_bin_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;

    state_t      state;
    logic [11:0] bcd;
    logic [9:0]  mag;
    logic [3:0]  cnt;
    logic        sgn;
    logic        dig_err;
    logic [7:0]  out_r;
    logic        erro_r;
    logic        busy_r;
    logic        done_r;
    logic [21:0] sh;
    logic        fin_err;

    // Per-digit correction after a right shift: digits >= 8 lose 3.
    function automatic logic [11:0] adjust(input logic [11:0] v);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = (v[i*4 +: 4] >= 4'd8) ? (v[i*4 +: 4] - 4'd3) : v[i*4 +: 4];
        end
        return r;
    endfunction

    // Any digit above 9 is not decimal.
    function automatic logic bad_digit(input logic [3:0] c, input logic [3:0] d,
                                       input logic [3:0] u);
        return (c > 4'd9) || (d > 4'd9) || (u > 4'd9);
    endfunction

    // Magnitude must fit the signed 8-bit range for the given sign.
    function automatic logic out_of_range(input logic s, input logic [9:0] m);
        return (!s && (m > 10'd127)) || (s && (m > 10'd128));
    endfunction

    // Apply the sign to an in-range magnitude.
    function automatic logic [7:0] to_twos(input logic s, input logic [9:0] m);
        logic [7:0] m8;
        m8 = m[7:0];
        return s ? (~m8 + 8'd1) : m8;
    endfunction

    assign sh      = {bcd, mag} >> 1;
    assign fin_err = dig_err | out_of_range(sgn, mag);

    // Control FSM plus shift datapath; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bcd     <= '0;
            mag     <= '0;
            cnt     <= '0;
            sgn     <= 1'b0;
            dig_err <= 1'b0;
            out_r   <= '0;
            erro_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        bcd     <= {bus.centena, bus.dezena, bus.unidade};
                        sgn     <= bus.negative;
                        mag     <= '0;
                        cnt     <= '0;
                        dig_err <= bad_digit(bus.centena, bus.dezena, bus.unidade);
                        busy_r  <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    // Shifting continues even with a digit error so latency stays uniform.
                    bcd <= adjust(sh[21:10]);
                    mag <= sh[9:0];
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd9) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    erro_r <= fin_err;
                    out_r  <= fin_err ? 8'd0 : to_twos(sgn, mag);
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.out  = out_r;
    assign bus.erro = erro_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule
